audio_i2s_out: RTL and testbench
================================

Name: audio_i2s_out

Overview:
- Downstream stage of the soft MPEG audio decoder. It consumes the CPU's left/right sample register writes (0x10000010 / 0x10000020 decode done in top) and buffers stereo pairs in a FIFO.
- It serialises the pairs as a standard I2S stream: MSB first, data delayed one BCLK after LRCK.
- It replaces the behavioural underflow counters with a real fill level, a nearly-empty flag and an underflow count.

Parameters:
- DEPTH, 64: FIFO depth in stereo pairs; power of 2, at least 4.
- CLK_DIV, 8: clk cycles per BCLK half-period; at least 2.
- START_LEVEL, 32: fill level (pairs) required before playback starts; at most DEPTH.
- NEARLY_EMPTY_TH, 8: nearly-empty threshold (pairs).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  playback enable
- wr_left  in  1  left-sample write strobe (CPU cmd valid & write & address hit)
- wr_right  in  1  right-sample write strobe
- wr_data  in  32  CPU write data; bits [15:0] = signed PCM sample
- wr_ready  out  1  write accept; drives dmem_cmd_ready for the sample addresses
- fifo_level  out  $clog2(DEPTH)+1  stored pairs
- fifo_nearly_empty  out  1  fifo_level < NEARLY_EMPTY_TH
- underflow_cnt  out  32  saturating count of frames played with an empty FIFO
- underflow_clr  in  1  synchronous clear of underflow_cnt
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select (0 = left)
- i2s_sdata  out  1  serial data

Behaviour:
- Reset values:
  - FIFO empty; wr_ready=1; fifo_level=0; fifo_nearly_empty=1; underflow_cnt=0.
  - bclk, lrck and sdata = 0; state STOPPED; holding register=0; bit_cnt=31; div counter=0.
- Write side:
  - wr_ready = !full, combinational.
  - Left strobe with wr_ready: hold_l <= wr_data[15:0]. A second left strobe before a right strobe overwrites hold_l.
  - Right strobe with wr_ready: push {hold_l, wr_data[15:0]}.
  - Left and right strobes in the same cycle: push {wr_data[15:0], wr_data[15:0]} (mono).
  - Strobes while full are ignored; the CPU stalls on wr_ready=0.
  - fifo_level updates the cycle after push/pop. Simultaneous push and pop leaves the level unchanged.
- State machine:
  - STOPPED: outputs held at reset values; bit_cnt=31. Goes to PREFILL when enable=1.
  - PREFILL: BCLK stopped. Goes to RUNNING when fifo_level >= START_LEVEL.
  - RUNNING: BCLK toggles every CLK_DIV clk cycles.
  - enable=0 in any state: go to STOPPED immediately; outputs return to 0 next cycle. FIFO contents are kept, not flushed.
- Serialiser (RUNNING):
  - All output changes happen on the clk cycle in which bclk goes 1->0 (falling edge).
  - On each falling edge, bit_cnt increments mod 32.
  - Wrap 31->0 while FIFO non-empty: pop the head and load the 32-bit shift register {L,R}. Load happens in the same cycle as the pop.
  - Wrap 31->0 while FIFO empty: load zeros and increment underflow_cnt; saturate at 0xFFFFFFFF.
  - sdata = shift_reg[31]; the register shifts left on each falling edge after bit 0.
  - lrck = 1 for bit_cnt in 15..30, 0 otherwise, so LRCK leads the data MSB by one BCLK.
  - First falling edge after entering RUNNING is a 31->0 wrap, so a pop occurs.
  - Frame = 64*CLK_DIV clk cycles.
- underflow_clr has priority over an increment in the same cycle.
- Reset asserted mid-frame: all state clears asynchronously; partial frame and FIFO contents are lost.

Decomposition:
- Package audio_out_pkg:
  - state enum {STOPPED, PREFILL, RUNNING}
  - FRAME_BITS=32, SAMPLE_BITS=16
  - sample-address localparams 32'h10000010 / 32'h10000020 (used by top decode)
- Sub-module sync_fifo:
  - generic width/depth, single clock
  - ports push, pop, full, empty, level
  - instantiated with WIDTH=32; the serialiser and state machine stay in audio_i2s_out.

Test Plan:
- Reset, enable=1, write L=0x1234 then R=0xABCD, START_LEVEL=1 -> after first wrap, sdata carries 0x1234 MSB-first while lrck=0 (data 1 BCLK after lrck fall), then 0xABCD while lrck=1; fifo_level 1->0.
- Fill with 64 pairs, DEPTH=64 -> wr_ready=0; a 65th right write does not change fifo_level; after one pop, wr_ready=1 and the write is accepted.
- START_LEVEL=32, write 31 pairs -> bclk stays 0; 32nd pair -> bclk toggles with period 2*CLK_DIV=16 clk cycles.
- Drain the FIFO while running -> frames output zeros; underflow_cnt increments once per frame (3 after 3 empty frames); underflow_clr -> 0; fifo_nearly_empty=1 below 8 pairs.
- Same-cycle left+right strobe with wr_data=0x0000_7FFF -> popped frame is 0x7FFF7FFF.
- Assert reset mid-frame at bit_cnt=10 -> next cycle bclk, lrck and sdata = 0, fifo_level=0, underflow_cnt=0, wr_ready=1.

Source files
------------

// File: rtl/audio_out_pkg.sv
// audio_out_pkg: shared state type, frame geometry and CPU sample addresses
// for the I2S audio output stage.
package audio_out_pkg;
  typedef enum logic [1:0] {STOPPED, PREFILL, RUNNING} state_t;
  localparam int FRAME_BITS = 32;
  localparam int SAMPLE_BITS = 16;
  localparam logic [31:0] ADDR_LEFT = 32'h1000_0010;
  localparam logic [31:0] ADDR_RIGHT = 32'h1000_0020;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and an occupancy count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp];
  assign level  = r_cnt;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/audio_i2s_out.sv
// audio_i2s_out: buffers CPU-written stereo sample pairs and serialises them
// as a standard I2S stream (MSB first, data one BCLK behind LRCK).
module audio_i2s_out
  import audio_out_pkg::*;
#(
  parameter int DEPTH           = 64,
  parameter int CLK_DIV         = 8,
  parameter int START_LEVEL     = 32,
  parameter int NEARLY_EMPTY_TH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   wr_left,
  input  logic                   wr_right,
  input  logic [31:0]            wr_data,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fifo_nearly_empty,
  output logic [31:0]            underflow_cnt,
  input  logic                   underflow_clr,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  state_t                 r_state;
  state_t                 w_next;
  logic [SAMPLE_BITS-1:0] r_hold_l;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [FRAME_BITS-1:0]  w_din;
  logic [FRAME_BITS-1:0]  w_head;
  logic [BW-1:0]          r_bit;
  logic [DW-1:0]          r_div;
  logic [31:0]            r_uf;
  logic                   r_bclk;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_run;
  logic                   w_div_end;
  logic                   w_fall;
  logic                   w_wrap;
  logic [$clog2(DEPTH):0] w_level;
  logic                   w_unused;
  assign w_unused = &{1'b0, wr_data[31:SAMPLE_BITS]};
  assign wr_ready = !w_full;
  assign w_push   = wr_right && wr_ready;
  // A same-cycle left+right strobe is a mono write: the sample fills both channels.
  assign w_din = wr_left ? {wr_data[SAMPLE_BITS-1:0], wr_data[SAMPLE_BITS-1:0]}
                         : {r_hold_l, wr_data[SAMPLE_BITS-1:0]};
  sync_fifo #(.WIDTH(FRAME_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );
  assign fifo_level        = w_level;
  assign fifo_nearly_empty = int'(w_level) < NEARLY_EMPTY_TH;
  assign underflow_cnt     = r_uf;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_hold_l <= '0;
    else if (wr_left && wr_ready) r_hold_l <= wr_data[SAMPLE_BITS-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= STOPPED;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = !enable ? STOPPED
           : (r_state == STOPPED) ? PREFILL
           : (r_state == PREFILL && int'(w_level) >= START_LEVEL) ? RUNNING
           : r_state;
  end
  // Gating with enable lets the outputs return to idle one cycle after enable drops.
  assign w_run     = (r_state == RUNNING) && enable;
  assign w_div_end = r_div == DW'(CLK_DIV - 1);
  assign w_fall    = w_run && w_div_end && r_bclk;
  assign w_wrap    = w_fall && (r_bit == BW'(FRAME_BITS - 1));
  assign w_pop     = w_wrap && !w_empty;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bclk  <= 1'b0;
      r_div   <= '0;
      r_bit   <= BW'(FRAME_BITS - 1);
      r_shift <= '0;
    end else if (!w_run) begin
      r_bclk  <= 1'b0;
      r_div   <= '0;
      r_bit   <= BW'(FRAME_BITS - 1);
      r_shift <= '0;
    end else begin
      r_div <= w_div_end ? '0 : r_div + DW'(1);
      if (w_div_end) r_bclk <= !r_bclk;
      if (w_fall) begin
        r_bit   <= r_bit + BW'(1);
        r_shift <= w_wrap ? (w_empty ? '0 : w_head) : r_shift << 1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_uf <= '0;
    else if (underflow_clr) r_uf <= '0;
    else if (w_wrap && w_empty && r_uf != '1) r_uf <= r_uf + 32'd1;
  end
  assign i2s_bclk  = r_bclk;
  assign i2s_sdata = r_shift[FRAME_BITS-1];
  // High for bits 15..30 so LRCK changes one BCLK ahead of each word's MSB.
  assign i2s_lrck  = (r_bit >= BW'(SAMPLE_BITS - 1)) && (r_bit != BW'(FRAME_BITS - 1));
endmodule

// File: tb/tb_audio_i2s_out.sv
// tb_audio_i2s_out: random writes feed a queue model of stored pairs; an I2S
// receiver process deserialises frames and checks them against a scoreboard.
module tb_audio_i2s_out;
  localparam int DEPTH = 64;
  localparam int CLK_DIV = 4;
  localparam int START_LEVEL = 32;
  localparam int NE_TH = 8;
  typedef struct {
    logic [31:0] data;
    int          stamp;
  } ent_t;
  logic        clk = 0;
  logic        reset = 1;
  logic        enable = 0;
  logic        wr_left = 0;
  logic        wr_right = 0;
  logic [31:0] wr_data = 0;
  logic        underflow_clr = 0;
  logic        wr_ready;
  logic [6:0]  fifo_level;
  logic        fifo_nearly_empty;
  logic [31:0] underflow_cnt;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  ent_t        m_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] m_hold = 0;
  int          m_uf = 0;
  int          nfall = 0;
  int          toggles = 0;
  int          frames = 0;

  audio_i2s_out #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .START_LEVEL(START_LEVEL),
                  .NEARLY_EMPTY_TH(NE_TH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_left(wr_left), .wr_right(wr_right),
    .wr_data(wr_data), .wr_ready(wr_ready), .fifo_level(fifo_level),
    .fifo_nearly_empty(fifo_nearly_empty), .underflow_cnt(underflow_cnt),
    .underflow_clr(underflow_clr), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // One write cycle; the model only sees what the DUT is able to accept.
  task automatic wr(input bit l, input bit r, input logic [31:0] d);
    bit acc;
    wr_left = l;
    wr_right = r;
    wr_data = d;
    #1;
    acc = wr_ready;
    if (acc && l && r) m_q.push_back('{{d[15:0], d[15:0]}, cyc + 1});
    else if (acc && r) m_q.push_back('{{m_hold, d[15:0]}, cyc + 1});
    if (acc && l && !r) m_hold = d[15:0];
    @(posedge clk);
    #1;
    wr_left = 0;
    wr_right = 0;
  endtask

  task automatic pair(input logic [31:0] l, input logic [31:0] r);
    wr(1, 0, l);
    wr(0, 1, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // I2S receiver: every 32nd falling BCLK is a frame start, when the model
  // decides whether a stored pair or silence is due.
  initial begin
    logic        pb;
    logic [31:0] sh;
    logic [31:0] lv;
    logic [31:0] e;
    int          k;
    pb = 0;
    sh = 0;
    lv = 0;
    forever begin
      @(negedge clk);
      if (reset || !enable) begin
        exp_q.delete();
        nfall = 0;
        pb = 0;
      end else begin
        if (i2s_bclk != pb) toggles++;
        if (pb && !i2s_bclk) begin
          if (nfall % 32 == 0) begin
            if (m_q.size() > 0 && m_q[0].stamp < cyc) e = m_q.pop_front().data;
            else begin
              e = 0;
              m_uf++;
            end
            exp_q.push_back(e);
          end
          nfall++;
        end else if (!pb && i2s_bclk && nfall > 0) begin
          k = (nfall - 1) % 32;
          sh = {sh[30:0], i2s_sdata};
          lv = {lv[30:0], i2s_lrck};
          if (k == 31) begin
            frames++;
            if (exp_q.size() == 0) timeout("frame_expected");
            else chk("frame_data", sh, exp_q.pop_front());
            chk("frame_lrck", lv, 32'h0001_FFFE);
          end
        end
        pb = i2s_bclk;
      end
    end
  end

  initial begin
    int n;
    int c0;
    int got;
    logic pb2;
    idle(3);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_nearly_empty", fifo_nearly_empty, 1);
    chk("rst_underflow", underflow_cnt, 0);
    chk("rst_outputs", {i2s_bclk, i2s_lrck, i2s_sdata}, 0);
    reset = 0;
    idle(2);
    // Fill to full while stopped.
    pair(32'h0000_1234, 32'h0000_ABCD);
    wr(1, 1, 32'h0000_7FFF);
    wr(1, 0, $urandom);
    pair($urandom, $urandom);
    for (int i = 3; i < DEPTH; i++) pair($urandom, $urandom);
    chk("full_level", fifo_level, DEPTH);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_nearly_empty", fifo_nearly_empty, 0);
    wr(0, 1, $urandom);
    chk("full_ignored_level", fifo_level, DEPTH);
    // Playback: first pop frees one slot.
    enable = 1;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) timeout("wait_first_pop");
    @(posedge clk);
    #1;
    chk("after_pop_level", fifo_level, DEPTH - 1);
    pair($urandom, $urandom);
    chk("refill_level", fifo_level, DEPTH);
    chk("refill_wr_ready", wr_ready, 0);
    // Drain and underflow.
    n = 0;
    while (fifo_level != NE_TH && n < 25000) begin
      @(negedge clk);
      n++;
    end
    if (fifo_level != NE_TH) timeout("wait_level_th");
    else chk("ne_at_th", fifo_nearly_empty, 0);
    n = 0;
    while (fifo_level != NE_TH - 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (fifo_level != NE_TH - 1) timeout("wait_level_below_th");
    else chk("ne_below_th", fifo_nearly_empty, 1);
    n = 0;
    while (m_uf < 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (m_uf < 3) timeout("wait_underflow");
    chk("underflow_3", underflow_cnt, 3);
    chk("empty_level", fifo_level, 0);
    @(posedge clk);
    #1;
    underflow_clr = 1;
    m_uf = 0;
    idle(1);
    underflow_clr = 0;
    chk("underflow_clr", underflow_cnt, 0);
    // Stop, then prefill below and at the start threshold.
    enable = 0;
    idle(2);
    chk("stop_outputs", {i2s_bclk, i2s_lrck, i2s_sdata}, 0);
    for (int i = 0; i < START_LEVEL - 1; i++) pair($urandom, $urandom);
    chk("prefill_level", fifo_level, START_LEVEL - 1);
    c0 = toggles;
    enable = 1;
    idle(40);
    chk("prefill_bclk_idle", toggles - c0, 0);
    chk("prefill_outputs", {i2s_bclk, i2s_lrck, i2s_sdata}, 0);
    pair($urandom, $urandom);
    got = 0;
    c0 = 0;
    pb2 = i2s_bclk;
    for (int i = 0; i < 200 && got < 2; i++) begin
      @(negedge clk);
      if (i2s_bclk && !pb2) begin
        if (got == 1) chk("bclk_period", cyc - c0, 2 * CLK_DIV);
        c0 = cyc;
        got++;
      end
      pb2 = i2s_bclk;
    end
    if (got < 2) timeout("bclk_start");
    @(posedge clk);
    #1;
    // Random writes interleaved with playback.
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(300));
      case ($urandom_range(2))
        0: pair($urandom, $urandom);
        1: begin
          wr(1, 1, $urandom);
          wr(1, 0, $urandom);
          wr(0, 1, $urandom);
        end
        default: begin
          wr(1, 0, $urandom);
          pair($urandom, $urandom);
        end
      endcase
    end
    for (int i = 0; i < 4; i++) pair($urandom, $urandom);
    // Reset in the middle of a frame.
    n = 0;
    while (!(nfall > 0 && (nfall - 1) % 32 == 10) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) timeout("wait_bit10");
    @(posedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    chk("midrst_outputs", {i2s_bclk, i2s_lrck, i2s_sdata}, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_underflow", underflow_cnt, 0);
    chk("midrst_wr_ready", wr_ready, 1);
    m_q.delete();
    m_hold = 0;
    @(posedge clk);
    #1;
    reset = 0;
    if (frames < 50) timeout("frames_seen");
    idle(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
